dip_mode_counter: RTL and testbench

- Parametrised successor to the board LED counter.
- Counts at a prescaled rate in one of four DIP-selected modes: hold, up, down, bounce.
- Loads a preset from the DIP switches on a load edge. Wraps or saturates per parameter.
- Drives the LED bank directly. Emits a one-cycle terminal-count pulse for chaining or status LEDs.

---
 rtl/dip_mode_counter_pkg.sv | 11 +
 rtl/dip_mode_counter_if.sv | 17 +
 rtl/dip_mode_counter_tick_prescaler.sv | 30 +++
 rtl/dip_mode_counter.sv | 112 +++++++++++
 tb/tb_dip_mode_counter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/dip_mode_counter_pkg.sv
// Shared definitions for the DIP-selected mode counter: mode type and encodings.
package dip_mode_counter_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_HOLD   = 2'b00;
   localparam mode_t MODE_UP     = 2'b01;
   localparam mode_t MODE_DOWN   = 2'b10;
   localparam mode_t MODE_BOUNCE = 2'b11;

endpackage

// File: rtl/dip_mode_counter_if.sv
// Board-side bundle of the mode counter: DIP preset, mode/load controls, LED outputs.
interface dip_mode_counter_if #(
   parameter int WIDTH = 8
);
   import dip_mode_counter_pkg::*;

   logic [WIDTH-1:0] DPSwitch;
   mode_t            mode;
   logic             load;
   logic [WIDTH-1:0] outleds;
   logic             dir;
   logic             tc;

   modport master (output DPSwitch, mode, load, input outleds, dir, tc);
   modport slave  (input DPSwitch, mode, load, output outleds, dir, tc);

endinterface

// File: rtl/dip_mode_counter_tick_prescaler.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks, restartable via clr.
module tick_prescaler #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   // A one-bit counter parked at zero covers TICK_DIV == 1 (tick every cycle).
   localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] cnt_q;

   assign tick = (cnt_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (clr || tick) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + ONE;
      end
   end

endmodule

// File: rtl/dip_mode_counter.sv
// Prescaled LED counter with hold/up/down/bounce modes, edge-triggered DIP preset load
// and a one-cycle terminal-count pulse.
module dip_mode_counter
   import dip_mode_counter_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 4,
   parameter int SATURATE = 0
) (
   input  logic                clk,
   input  logic                reset,
   dip_mode_counter_if.slave   bus
);

   localparam logic [WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [WIDTH-1:0] CNT_MAX_M1 = {{(WIDTH-1){1'b1}}, 1'b0};
   localparam logic [WIDTH-1:0] CNT_ONE    = WIDTH'(1);
   localparam bit               SAT        = (SATURATE != 0);

   logic             load_q;
   logic             ld;
   logic             tick;
   logic [WIDTH-1:0] count_q, count_d;
   logic             dir_q, dir_d;
   logic             tc_q, tc_d;

   assign ld = bus.load & ~load_q;

   // A load restarts the prescaler so the first step after a preset is a full period away.
   tick_prescaler #(
      .TICK_DIV (TICK_DIV)
   ) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .clr   (ld),
      .tick  (tick)
   );

   always_comb begin
      count_d = count_q;
      dir_d   = dir_q;
      tc_d    = 1'b0;
      if (ld) begin
         count_d = bus.DPSwitch;
      end else if (tick) begin
         case (bus.mode)
            MODE_UP: begin
               dir_d = 1'b1;
               if (count_q != CNT_MAX) begin
                  count_d = count_q + CNT_ONE;
                  tc_d    = SAT && (count_q == CNT_MAX_M1);
               end else if (!SAT) begin
                  count_d = '0;
                  tc_d    = 1'b1;
               end
            end
            MODE_DOWN: begin
               dir_d = 1'b0;
               if (count_q != '0) begin
                  count_d = count_q - CNT_ONE;
                  tc_d    = SAT && (count_q == CNT_ONE);
               end else if (!SAT) begin
                  count_d = CNT_MAX;
                  tc_d    = 1'b1;
               end
            end
            MODE_BOUNCE: begin
               // Bounce turns around at the rails regardless of SATURATE.
               if (dir_q) begin
                  if (count_q == CNT_MAX) begin
                     count_d = CNT_MAX_M1;
                     dir_d   = 1'b0;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = count_q + CNT_ONE;
                  end
               end else begin
                  if (count_q == '0) begin
                     count_d = CNT_ONE;
                     dir_d   = 1'b1;
                     tc_d    = 1'b1;
                  end else begin
                     count_d = count_q - CNT_ONE;
                  end
               end
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_q  <= 1'b0;
         count_q <= '0;
         dir_q   <= 1'b1;
         tc_q    <= 1'b0;
      end else begin
         load_q  <= bus.load;
         count_q <= count_d;
         dir_q   <= dir_d;
         tc_q    <= tc_d;
      end
   end

   assign bus.outleds = count_q;
   assign bus.dir     = dir_q;
   assign bus.tc      = tc_q;

endmodule

// File: tb/tb_dip_mode_counter.sv
// Directed bench for dip_mode_counter: wrap/TICK_DIV=4, saturating, and TICK_DIV=1 instances.
module tb_dip_mode_counter;

   typedef struct {
      logic [1:0] mode;
      logic       load;
      logic [7:0] dps;
      int         ncyc;
      logic [7:0] exp_out;
      logic       exp_dir;
      logic       exp_tc;
   } vec_t;

   logic clk;
   logic reset;
   int   tests = 0;
   int   fails = 0;
   vec_t tbl[$];

   dip_mode_counter_if #(.WIDTH(8)) bus_a ();
   dip_mode_counter_if #(.WIDTH(8)) bus_s ();
   dip_mode_counter_if #(.WIDTH(8)) bus_t ();

   dip_mode_counter #(.WIDTH(8), .TICK_DIV(4), .SATURATE(0)) u_dut_wrap (
      .clk(clk), .reset(reset), .bus(bus_a));
   dip_mode_counter #(.WIDTH(8), .TICK_DIV(4), .SATURATE(1)) u_dut_sat (
      .clk(clk), .reset(reset), .bus(bus_s));
   dip_mode_counter #(.WIDTH(8), .TICK_DIV(1), .SATURATE(0)) u_dut_fast (
      .clk(clk), .reset(reset), .bus(bus_t));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(input logic [1:0] mode, input logic load, input logic [7:0] dps,
                              input int n, input logic [7:0] out, input logic d, input logic t);
      vec_t r;
      r.mode = mode; r.load = load; r.dps = dps; r.ncyc = n;
      r.exp_out = out; r.exp_dir = d; r.exp_tc = t;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int pulses;

      // scenario 1: count up from reset
      tbl.push_back(v(2'b01, 1'b0, 8'h00, 3, 8'h00, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h00, 1, 8'h01, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h00, 1, 8'h01, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h00, 3, 8'h02, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h00, 4, 8'h03, 1'b1, 1'b0));
      // scenario 2: preset FD, wrap through FF->00
      tbl.push_back(v(2'b01, 1'b1, 8'hFD, 1, 8'hFD, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 3, 8'hFD, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 1, 8'hFE, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 4, 8'hFF, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 3, 8'hFF, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 1, 8'h00, 1'b1, 1'b1));
      tbl.push_back(v(2'b01, 1'b0, 8'hFD, 1, 8'h00, 1'b1, 1'b0));
      // scenario 4: bounce at bottom, then at top
      tbl.push_back(v(2'b10, 1'b1, 8'h02, 1, 8'h02, 1'b1, 1'b0));
      tbl.push_back(v(2'b10, 1'b0, 8'h02, 4, 8'h01, 1'b0, 1'b0));
      tbl.push_back(v(2'b11, 1'b0, 8'h02, 4, 8'h00, 1'b0, 1'b0));
      tbl.push_back(v(2'b11, 1'b0, 8'h02, 4, 8'h01, 1'b1, 1'b1));
      tbl.push_back(v(2'b11, 1'b0, 8'h02, 1, 8'h01, 1'b1, 1'b0));
      tbl.push_back(v(2'b11, 1'b0, 8'h02, 3, 8'h02, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b1, 8'hFE, 1, 8'hFE, 1'b1, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'hFE, 4, 8'hFF, 1'b1, 1'b0));
      tbl.push_back(v(2'b11, 1'b0, 8'hFE, 4, 8'hFE, 1'b0, 1'b1));
      tbl.push_back(v(2'b11, 1'b0, 8'hFE, 1, 8'hFE, 1'b0, 1'b0));
      // scenario 5: held load reloads once; load coinciding with tick wins
      tbl.push_back(v(2'b00, 1'b1, 8'h55, 1, 8'h55, 1'b0, 1'b0));
      tbl.push_back(v(2'b00, 1'b1, 8'hAA, 50, 8'h55, 1'b0, 1'b0));
      tbl.push_back(v(2'b00, 1'b1, 8'hAA, 50, 8'h55, 1'b0, 1'b0));
      tbl.push_back(v(2'b00, 1'b0, 8'hAA, 1, 8'h55, 1'b0, 1'b0));
      tbl.push_back(v(2'b01, 1'b1, 8'h10, 1, 8'h10, 1'b0, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h10, 3, 8'h10, 1'b0, 1'b0));
      tbl.push_back(v(2'b01, 1'b1, 8'h20, 1, 8'h20, 1'b0, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h20, 3, 8'h20, 1'b0, 1'b0));
      tbl.push_back(v(2'b01, 1'b0, 8'h20, 1, 8'h21, 1'b1, 1'b0));
      // down wrap 00->FF
      tbl.push_back(v(2'b10, 1'b1, 8'h00, 1, 8'h00, 1'b1, 1'b0));
      tbl.push_back(v(2'b10, 1'b0, 8'h00, 3, 8'h00, 1'b1, 1'b0));
      tbl.push_back(v(2'b10, 1'b0, 8'h00, 1, 8'hFF, 1'b0, 1'b1));

      bus_a.DPSwitch = 8'h00; bus_a.mode = 2'b00; bus_a.load = 1'b0;
      bus_s.DPSwitch = 8'h00; bus_s.mode = 2'b00; bus_s.load = 1'b0;
      bus_t.DPSwitch = 8'h00; bus_t.mode = 2'b00; bus_t.load = 1'b0;
      reset = 1'b1;
      #2 reset = 1'b0;
      #28;
      chk("reset.out", 32'(bus_a.outleds), 32'h00);
      chk("reset.dir", 32'(bus_a.dir), 32'h1);
      chk("reset.tc", 32'(bus_a.tc), 32'h0);
      bus_a.mode = 2'b01;
      #20 reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         bus_a.mode     = tbl[i].mode;
         bus_a.load     = tbl[i].load;
         bus_a.DPSwitch = tbl[i].dps;
         step(tbl[i].ncyc);
         chk($sformatf("vec%0d.out", i), 32'(bus_a.outleds), 32'(tbl[i].exp_out));
         chk($sformatf("vec%0d.dir", i), 32'(bus_a.dir), 32'(tbl[i].exp_dir));
         chk($sformatf("vec%0d.tc", i), 32'(bus_a.tc), 32'(tbl[i].exp_tc));
      end
      bus_a.mode = 2'b00;

      // scenario 3: saturating up parks at FF with a single tc pulse
      bus_s.DPSwitch = 8'hFD; bus_s.mode = 2'b01; bus_s.load = 1'b1;
      step(1);
      chk("sat.load", 32'(bus_s.outleds), 32'hFD);
      bus_s.load = 1'b0;
      step(4);
      chk("sat.fe", 32'(bus_s.outleds), 32'hFE);
      chk("sat.fe.tc", 32'(bus_s.tc), 32'h0);
      step(4);
      chk("sat.ff", 32'(bus_s.outleds), 32'hFF);
      chk("sat.ff.tc", 32'(bus_s.tc), 32'h1);
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step(1);
         pulses += int'(bus_s.tc);
      end
      chk("sat.parked.tc_pulses", 32'(pulses), 32'h0);
      chk("sat.parked.out", 32'(bus_s.outleds), 32'hFF);

      // saturating down stops at 00
      bus_s.DPSwitch = 8'h01; bus_s.mode = 2'b10; bus_s.load = 1'b1;
      step(1);
      bus_s.load = 1'b0;
      step(4);
      chk("satdn.00", 32'(bus_s.outleds), 32'h00);
      chk("satdn.tc", 32'(bus_s.tc), 32'h1);
      chk("satdn.dir", 32'(bus_s.dir), 32'h0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         pulses += int'(bus_s.tc);
      end
      chk("satdn.parked.tc_pulses", 32'(pulses), 32'h0);
      chk("satdn.parked.out", 32'(bus_s.outleds), 32'h00);

      // scenario 6: asynchronous reset between edges
      bus_a.DPSwitch = 8'h37; bus_a.load = 1'b1;
      step(1);
      bus_a.load = 1'b0;
      chk("async.pre.out", 32'(bus_a.outleds), 32'h37);
      chk("async.pre.dir", 32'(bus_a.dir), 32'h0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      chk("async.out", 32'(bus_a.outleds), 32'h00);
      chk("async.dir", 32'(bus_a.dir), 32'h1);
      chk("async.tc", 32'(bus_a.tc), 32'h0);
      chk("async.sat.out", 32'(bus_s.outleds), 32'h00);
      bus_a.mode = 2'b01;
      bus_t.mode = 2'b01;
      #3 reset = 1'b1;

      // TICK_DIV=1 steps each clock; the TICK_DIV=4 copy restarts its prescaler
      for (int k = 1; k <= 4; k++) begin
         step(1);
         chk($sformatf("fast.step%0d", k), 32'(bus_t.outleds), 32'(k));
         chk($sformatf("fast.tc%0d", k), 32'(bus_t.tc), 32'h0);
         chk($sformatf("wrap.after_rst%0d", k), 32'(bus_a.outleds), (k == 4) ? 32'h1 : 32'h0);
      end
      chk("fast.dir", 32'(bus_t.dir), 32'h1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
